// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file slice.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR,
    RF_IDLE
  } rf_state_t;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: walks cptr over the array after reset or a clear request.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          clear,
  output logic          ready,
  output logic          cwe,
  output logic [AW-1:0] cptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cptr_q, cptr_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    unique case (state_q)
      RF_CLEAR: begin
        cptr_d = cptr_q + AW'(1);
        if (cptr_q == LAST) begin
          state_d = RF_IDLE;
          cptr_d  = '0;
        end
      end
      RF_IDLE: begin
        if (clear) begin
          state_d = RF_CLEAR;
          cptr_d  = '0;
        end
      end
      default: begin
        state_d = RF_CLEAR;
        cptr_d  = '0;
      end
    endcase
    ready_d = (state_d == RF_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q <= RF_CLEAR;
      cptr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
      ready_q <= ready_d;
    end
  end

  // No clearing on a reset edge: the array is left alone by reset itself
  assign cwe   = n_reset && (state_q == RF_CLEAR);
  assign cptr  = cptr_q;
  assign ready = ready_q;

endmodule

// File: rtl/register_file.sv
// Multi-entry register file: 1 write port, 2 combinational read ports,
// sequential clear engine, optional zero register and write bypass.
module register_file
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 8,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 0,
  localparam int AW       = rf_aw(DEPTH)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             clear,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b,
  output logic             ready
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             cwe;
  logic [AW-1:0]    cptr;
  logic             accept;
  logic             mwe;
  logic [AW-1:0]    maddr;
  logic [WIDTH-1:0] mdata;

  regfile_clear_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fsm (
    .clk     (clk),
    .n_reset (n_reset),
    .clear   (clear),
    .ready   (ready),
    .cwe     (cwe),
    .cptr    (cptr)
  );

  always_comb begin
    accept = we && ready && n_reset
          && (int'(waddr) < DEPTH)
          && !((ZERO_REG != 0) && (waddr == '0));
  end

  // Single physical write port shared by the clear engine and the user
  always_comb begin
    mwe   = cwe || accept;
    maddr = cwe ? cptr : waddr;
    mdata = cwe ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (mwe) mem_q[maddr] <= mdata;
  end

  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if ((ZERO_REG != 0) && (a == '0)) v = '0;
    else if (int'(a) >= DEPTH)         v = '0;
    else if ((BYPASS != 0) && accept && (waddr == a)) v = wdata;
    else                               v = mem_q[a];
    return v;
  endfunction

  always_comb begin
    rdata_a = rd(raddr_a);
    rdata_b = rd(raddr_b);
  end

endmodule
